// File: rtl/karatsuba_seq_mul.sv
// Sequential one-level Karatsuba multiplier: three sub-products share one (H+1)x(H+1) multiplier.
// Define RESIDUE_CHECK_EN to build the mod-3 residue check and the fault_inj hook on z1.
module karatsuba_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 fault_inj,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 err
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        COMBINE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*H-1:0]       z0_q, z0_d, z2_q, z2_d;
    logic [2*H+1:0]       z1_q, z1_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 err_q, err_d;

    logic [H:0]           mulA, mulB;
    logic [2*H+1:0]       mulProd;
    logic [2*H+1:0]       midFull;
    logic [2*WIDTH-1:0]   pNext;
    logic                 faultBit;
    logic                 errNext;

    // The shared multiplier sees the half-words or their (H+1)-bit sums depending on the phase.
    always_comb begin
        mulA = '0;
        mulB = '0;
        case (state_q)
            MUL_LO: begin
                mulA = {1'b0, a_q[H-1:0]};
                mulB = {1'b0, b_q[H-1:0]};
            end
            MUL_HI: begin
                mulA = {1'b0, a_q[WIDTH-1:H]};
                mulB = {1'b0, b_q[WIDTH-1:H]};
            end
            MUL_MID: begin
                mulA = {1'b0, a_q[H-1:0]} + {1'b0, a_q[WIDTH-1:H]};
                mulB = {1'b0, b_q[H-1:0]} + {1'b0, b_q[WIDTH-1:H]};
            end
            default: begin
            end
        endcase
    end

    assign mulProd = (2*H+2)'(mulA) * (2*H+2)'(mulB);

    // mid is never negative, so its top bit is zero and the full-width sum is exact before truncation.
    assign midFull = z1_q - (2*H+2)'(z0_q) - (2*H+2)'(z2_q);
    assign pNext   = (2*WIDTH)'((PW'(z2_q) << (2*H)) + (PW'(midFull) << H) + PW'(z0_q));

`ifdef RESIDUE_CHECK_EN
    function automatic logic [1:0] mod3(input logic [2*WIDTH-1:0] v);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s = s + 16'(v[2*i +: 2]);
        end
        return 2'(s % 16'd3);
    endfunction

    logic [1:0] ra, rb, resExp, resAct;
    logic [3:0] rProd;

    assign ra       = mod3((2*WIDTH)'(a_q));
    assign rb       = mod3((2*WIDTH)'(b_q));
    assign rProd    = {2'b00, ra} * {2'b00, rb};
    assign resExp   = 2'(rProd % 4'd3);
    assign resAct   = mod3(pNext);
    assign errNext  = (resExp != resAct);
    assign faultBit = fault_inj;
`else
    logic unusedFault;
    assign unusedFault = fault_inj;
    assign errNext     = 1'b0;
    assign faultBit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z0_d    = z0_q;
        z2_d    = z2_q;
        z1_d    = z1_q;
        p_d     = p_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = MUL_LO;
                end
            end
            MUL_LO: begin
                z0_d    = mulProd[2*H-1:0];
                state_d = MUL_HI;
            end
            MUL_HI: begin
                z2_d    = mulProd[2*H-1:0];
                state_d = MUL_MID;
            end
            MUL_MID: begin
                z1_d    = mulProd ^ {{(2*H+1){1'b0}}, faultBit};
                state_d = COMBINE;
            end
            COMBINE: begin
                p_d     = pNext;
                err_d   = errNext;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z0_q    <= '0;
            z2_q    <= '0;
            z1_q    <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z0_q    <= z0_d;
            z2_q    <= z2_d;
            z1_q    <= z1_d;
            p_q     <= p_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;
    assign err       = err_q;

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Directed bench for karatsuba_seq_mul: an 8-bit and a 16-bit instance driven with hand-computed vectors.
// Fault-injection expectations depend on whether RESIDUE_CHECK_EN is defined for the build.
module tb_karatsuba_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        inValid8, inReady8, fault8, outValid8, outReady8, err8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        inValid16, inReady16, fault16, outValid16, outReady16, err16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int testsRun    = 0;
    int testsFailed = 0;

    karatsuba_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .fault_inj(fault8), .out_valid(outValid8),
        .out_ready(outReady8), .p(p8), .err(err8)
    );

    karatsuba_seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid16), .in_ready(inReady16),
        .a(a16), .b(b16), .fault_inj(fault16), .out_valid(outValid16),
        .out_ready(outReady16), .p(p16), .err(err16)
    );

    // Offer one operand pair to the 8-bit unit and return at the negedge of its first DONE cycle.
    // Operands are scrambled after the accept edge so the result must come from the latched copy.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic inj, input logic holdValid,
                        output logic [15:0] pr, output logic e, output int lat, output logic readyAtStart);
        @(negedge clk);
        readyAtStart = inReady8;
        a8 = x;
        b8 = y;
        inValid8 = 1'b1;
        @(negedge clk);
        inValid8 = holdValid;
        a8 = ~x;
        b8 = ~y;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            fault8 = (n == 3) ? inj : 1'b0;
            if (outValid8) begin
                lat = n;
                break;
            end
        end
        pr = p8;
        e = err8;
        inValid8 = 1'b0;
        fault8 = 1'b0;
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] pr, output logic e, output int lat);
        @(negedge clk);
        a16 = x;
        b16 = y;
        inValid16 = 1'b1;
        @(negedge clk);
        inValid16 = 1'b0;
        a16 = ~x;
        b16 = ~y;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (outValid16) begin
                lat = n;
                break;
            end
        end
        pr = p16;
        e = err16;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++; if (inReady8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready8: got %b expected 1", inReady8); end
        testsRun++; if (outValid8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid8: got %b expected 0", outValid8); end
        testsRun++; if (p8 !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_p8: got %0d expected 0", p8); end
        testsRun++; if (err8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err8: got %b expected 0", err8); end
        testsRun++; if (inReady16 !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready16: got %b expected 1", inReady16); end
        testsRun++; if (p16 !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_p16: got %0d expected 0", p16); end
    endtask

    task automatic test_basic();
        logic [15:0] pr; logic e; int lat; logic rdy;
        outReady8 = 1'b1;
        run8(8'd150, 8'd160, 1'b0, 1'b0, pr, e, lat, rdy);
        testsRun++; if (rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic1_in_ready: got %b expected 1", rdy); end
        testsRun++; if (lat != 5) begin testsFailed++; $display("[TB] FAIL basic1_latency: got %0d expected 5", lat); end
        testsRun++; if (pr !== 16'd24000) begin testsFailed++; $display("[TB] FAIL basic1_p: got %0d expected 24000", pr); end
        testsRun++; if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic1_err: got %b expected 0", e); end
        run8(8'd56, 8'd78, 1'b0, 1'b0, pr, e, lat, rdy);
        testsRun++; if (rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic2_in_ready: got %b expected 1", rdy); end
        testsRun++; if (pr !== 16'd4368) begin testsFailed++; $display("[TB] FAIL basic2_p: got %0d expected 4368", pr); end
        testsRun++; if (lat != 5) begin testsFailed++; $display("[TB] FAIL basic2_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_wide();
        logic [31:0] pr; logic e; int lat;
        outReady16 = 1'b1;
        run16(16'd65535, 16'd65535, pr, e, lat);
        testsRun++; if (pr !== 32'd4294836225) begin testsFailed++; $display("[TB] FAIL wide_max_p: got %0d expected 4294836225", pr); end
        testsRun++; if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL wide_max_err: got %b expected 0", e); end
        testsRun++; if (lat != 5) begin testsFailed++; $display("[TB] FAIL wide_max_latency: got %0d expected 5", lat); end
        run16(16'd0, 16'd12345, pr, e, lat);
        testsRun++; if (pr !== 32'd0) begin testsFailed++; $display("[TB] FAIL wide_zero_p: got %0d expected 0", pr); end
        testsRun++; if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL wide_zero_err: got %b expected 0", e); end
    endtask

    task automatic test_backpressure();
        logic [15:0] pr; logic e; int lat; logic rdy;
        outReady8 = 1'b0;
        run8(8'd222, 8'd32, 1'b0, 1'b0, pr, e, lat, rdy);
        testsRun++; if (pr !== 16'd7104) begin testsFailed++; $display("[TB] FAIL bp_p_first: got %0d expected 7104", pr); end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            testsRun++; if (outValid8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_out_valid_hold: cycle %0d got %b expected 1", k, outValid8); end
            testsRun++; if (p8 !== 16'd7104) begin testsFailed++; $display("[TB] FAIL bp_p_hold: cycle %0d got %0d expected 7104", k, p8); end
            testsRun++; if (inReady8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_in_ready_hold: cycle %0d got %b expected 0", k, inReady8); end
        end
        outReady8 = 1'b1;
        @(negedge clk);
        testsRun++; if (inReady8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_in_ready_after: got %b expected 1", inReady8); end
        testsRun++; if (outValid8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_out_valid_after: got %b expected 0", outValid8); end
    endtask

    task automatic test_residue();
        logic [15:0] pr; logic e; int lat; logic rdy;
        outReady8 = 1'b1;
        run8(8'd189, 8'd167, 1'b1, 1'b0, pr, e, lat, rdy);
`ifdef RESIDUE_CHECK_EN
        testsRun++; if (pr !== 16'd31579) begin testsFailed++; $display("[TB] FAIL residue_fault_p: got %0d expected 31579", pr); end
        testsRun++; if (e !== 1'b1) begin testsFailed++; $display("[TB] FAIL residue_fault_err: got %b expected 1", e); end
`else
        testsRun++; if (pr !== 16'd31563) begin testsFailed++; $display("[TB] FAIL residue_fault_ignored_p: got %0d expected 31563", pr); end
        testsRun++; if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL residue_fault_ignored_err: got %b expected 0", e); end
`endif
        run8(8'd189, 8'd167, 1'b0, 1'b0, pr, e, lat, rdy);
        testsRun++; if (pr !== 16'd31563) begin testsFailed++; $display("[TB] FAIL residue_clean_p: got %0d expected 31563", pr); end
        testsRun++; if (e !== 1'b0) begin testsFailed++; $display("[TB] FAIL residue_clean_err: got %b expected 0", e); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] pr; logic e; int lat; logic rdy; logic seen;
        outReady8 = 1'b1;
        @(negedge clk);
        a8 = 8'd190;
        b8 = 8'd180;
        inValid8 = 1'b1;
        @(negedge clk);
        inValid8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        testsRun++; if (inReady8 !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", inReady8); end
        testsRun++; if (outValid8 !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", outValid8); end
        testsRun++; if (p8 !== 16'd0) begin testsFailed++; $display("[TB] FAIL midreset_p: got %0d expected 0", p8); end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (outValid8) seen = 1'b1;
        end
        testsRun++; if (seen !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_no_output: got %b expected 0", seen); end
        run8(8'd190, 8'd180, 1'b0, 1'b0, pr, e, lat, rdy);
        testsRun++; if (pr !== 16'd34200) begin testsFailed++; $display("[TB] FAIL midreset_retry_p: got %0d expected 34200", pr); end
        testsRun++; if (lat != 5) begin testsFailed++; $display("[TB] FAIL midreset_retry_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pr; logic e; int lat; logic rdy;
        outReady8 = 1'b1;
        run8(8'd255, 8'd255, 1'b0, 1'b1, pr, e, lat, rdy);
        testsRun++; if (pr !== 16'd65025) begin testsFailed++; $display("[TB] FAIL b2b_first_p: got %0d expected 65025", pr); end
        testsRun++; if (lat != 5) begin testsFailed++; $display("[TB] FAIL b2b_first_latency: got %0d expected 5", lat); end
        run8(8'd17, 8'd3, 1'b0, 1'b1, pr, e, lat, rdy);
        testsRun++; if (rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", rdy); end
        testsRun++; if (pr !== 16'd51) begin testsFailed++; $display("[TB] FAIL b2b_second_p: got %0d expected 51", pr); end
    endtask

    initial begin
        rst_n = 1'b0;
        inValid8 = 1'b0; fault8 = 1'b0; outReady8 = 1'b1; a8 = '0; b8 = '0;
        inValid16 = 1'b0; fault16 = 1'b0; outReady16 = 1'b1; a16 = '0; b16 = '0;
        test_reset();
        test_basic();
        test_wide();
        test_backpressure();
        test_residue();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
